// File: rtl/debug_cmd_ctrl.sv
// debug_cmd_ctrl: single-byte command sequencer for the UART debug link.
// Decodes received commands, returns one reply byte per command through the
// transmitter, owns the LED register and samples the probe port.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for a command byte
// GET_ARG   | 'W' received, waiting for the argument byte or timeout
// SEND      | reply loaded in tx_byte, waiting for the transmitter to be free
// WAIT_ACC  | tx_start issued, waiting for tx_busy to rise
// WAIT_DONE | reply in flight, waiting for tx_busy to fall

module debug_cmd_ctrl #(
    parameter logic [7:0] ID_BYTE        = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 12_000_000
) (
    input  logic       iCE_CLK,
    input  logic       RST_N,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    input  logic [7:0] probe_in,
    output logic [3:0] led,
    output logic       err_drop
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_P = 8'h50;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_I = 8'h49;
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_ARG   = 3'd1,
        SEND      = 3'd2,
        WAIT_ACC  = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [3:0]       led_q, led_d;
    logic             err_drop_q, err_drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       probe_m_q, probe_s_q;

    // Next-state and output decode; outputs are registered so tx_start is glitch-free.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        led_d      = led_q;
        err_drop_d = err_drop_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    state_d = SEND;
                    unique case (rx_byte)
                        CMD_P:   tx_byte_d = probe_s_q;
                        CMD_R:   tx_byte_d = {4'h0, led_q};
                        CMD_I:   tx_byte_d = ID_BYTE;
                        CMD_W: begin
                            state_d = GET_ARG;
                            cnt_d   = '0;
                        end
                        default: tx_byte_d = NAK;
                    endcase
                end
            end
            GET_ARG: begin
                cnt_d = cnt_q + 1'b1;
                // An argument arriving in the terminal cycle still counts.
                if (rx_valid) begin
                    led_d     = rx_byte[3:0];
                    tx_byte_d = ACK;
                    state_d   = SEND;
                end else if (cnt_q == CNT_LAST) begin
                    tx_byte_d = NAK;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = WAIT_ACC;
                end
            end
            WAIT_ACC: begin
                if (tx_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // No queueing: anything received while a reply is pending is lost.
        if (rx_valid && (state_q == SEND || state_q == WAIT_ACC || state_q == WAIT_DONE))
            err_drop_d = 1'b1;
    end

    // State, output and probe synchroniser registers.
    always_ff @(posedge iCE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            led_q      <= 4'h0;
            err_drop_q <= 1'b0;
            cnt_q      <= '0;
            probe_m_q  <= 8'h00;
            probe_s_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
            led_q      <= led_d;
            err_drop_q <= err_drop_d;
            cnt_q      <= cnt_d;
            probe_m_q  <= probe_in;
            probe_s_q  <= probe_m_q;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_byte  = tx_byte_q;
    assign led      = led_q;
    assign err_drop = err_drop_q;

endmodule

// File: tb/tb_debug_cmd_ctrl.sv
// Directed bench for debug_cmd_ctrl with a small transmitter model.
module tb_debug_cmd_ctrl;

    localparam int BUSY_LEN = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic [7:0] probe_in = 8'h00;
    logic [3:0] led;
    logic       err_drop;

    int n_checks = 0;
    int n_fail   = 0;
    int starts   = 0;
    int busy_cnt = 0;
    logic [7:0] last_byte = 8'h00;

    debug_cmd_ctrl #(.ID_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
        .iCE_CLK (clk),
        .RST_N   (rst_n),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .tx_busy (tx_busy),
        .tx_start(tx_start),
        .tx_byte (tx_byte),
        .probe_in(probe_in),
        .led     (led),
        .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy from the cycle after tx_start for BUSY_LEN cycles.
    always @(negedge clk) begin
        if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (tx_start === 1'b1) begin
            starts    = starts + 1;
            last_byte = tx_byte;
            tx_busy   = 1'b1;
            busy_cnt  = BUSY_LEN;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; rx_valid is sampled on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_reply(input int base, output logic [7:0] got);
        int k = 0;
        while (!(starts > base && !tx_busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("reply_timeout", (k < 300) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        @(negedge clk);
        got = last_byte;
    endtask

    task automatic cmd(input string tag, input logic [7:0] c, input logic [7:0] exp);
        int base = starts;
        logic [7:0] got;
        send_byte(c);
        wait_reply(base, got);
        check({tag, "_byte"}, {24'h0, got}, {24'h0, exp});
        check({tag, "_starts"}, starts - base, 1);
    endtask

    initial begin
        int base;
        logic [7:0] got;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_tx_start", {31'h0, tx_start}, 0);
        check("rst_tx_byte", {24'h0, tx_byte}, 0);
        check("rst_led", {28'h0, led}, 0);
        check("rst_err_drop", {31'h0, err_drop}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. 'I' with latency check: tx_start two edges after the sampled rx_valid
        base = starts;
        send_byte(8'h49);
        check("lat_no_start_early", {31'h0, tx_start}, 0);
        @(negedge clk);
        check("lat_start", {31'h0, tx_start}, 1);
        check("lat_byte", {24'h0, tx_byte}, 32'hA5);
        @(negedge clk);
        check("start_one_cycle", {31'h0, tx_start}, 0);
        wait_reply(base, got);
        check("id_starts", starts - base, 1);
        check("id_byte", {24'h0, got}, 32'hA5);

        // 2. probe sampling through the synchroniser
        probe_in = 8'h3C;
        repeat (3) @(negedge clk);
        cmd("probe_3c", 8'h50, 8'h3C);
        probe_in = 8'hC3;
        repeat (3) @(negedge clk);
        cmd("probe_c3", 8'h50, 8'hC3);

        // 3. write LEDs then read back
        send_byte(8'h57);
        @(negedge clk);
        base = starts;
        send_byte(8'h0B);
        check("led_after_arg", {28'h0, led}, 32'hB);
        check("led_no_start_yet", starts - base, 0);
        wait_reply(base, got);
        check("w_ack", {24'h0, got}, 32'h06);
        cmd("read_led", 8'h52, 8'h0B);

        // 4. argument timeout: NAK exactly after 16 counting cycles
        base = starts;
        send_byte(8'h57);
        repeat (16) @(negedge clk);
        check("to_no_start_early", {31'h0, tx_start}, 0);
        check("to_starts_early", starts - base, 0);
        @(negedge clk);
        check("to_start", {31'h0, tx_start}, 1);
        check("to_nak_byte", {24'h0, tx_byte}, 32'h15);
        wait_reply(base, got);
        check("to_led_kept", {28'h0, led}, 32'hB);

        // argument in the terminal cycle wins over the timeout
        base = starts;
        send_byte(8'h57);
        repeat (15) @(negedge clk);
        send_byte(8'h07);
        wait_reply(base, got);
        check("term_ack", {24'h0, got}, 32'h06);
        check("term_led", {28'h0, led}, 32'h7);
        check("term_starts", starts - base, 1);
        cmd("read_led7", 8'h52, 8'h07);

        // 5. unknown command, then a byte injected during WAIT_DONE
        check("no_err_yet", {31'h0, err_drop}, 0);
        base = starts;
        send_byte(8'h58);
        repeat (6) @(negedge clk);
        send_byte(8'h49);
        wait_reply(base, got);
        check("x_nak", {24'h0, got}, 32'h15);
        check("drop_starts", starts - base, 1);
        check("err_drop_set", {31'h0, err_drop}, 1);
        repeat (5) @(negedge clk);
        check("drop_no_extra", starts - base, 1);

        // 6. reset during WAIT_DONE
        base = starts;
        send_byte(8'h49);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_start", {31'h0, tx_start}, 0);
        check("mid_rst_led", {28'h0, led}, 0);
        check("mid_rst_err", {31'h0, err_drop}, 0);
        check("mid_rst_tx_byte", {24'h0, tx_byte}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        while (tx_busy) @(negedge clk);
        @(negedge clk);
        cmd("post_rst_read", 8'h52, 8'h00);
        check("post_rst_err", {31'h0, err_drop}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
